ra_2r1w_32x32_ctl: RTL and testbench
====================================

# ra_2r1w_32x32_ctl

Sequencing and arbitration controller in front of the 2R1W 32x32 SDR register-array wrapper.
- After reset or on `clear`, initialises all 32 entries to `INIT_VAL`.
- Gives each of two clients (A, B) a dedicated read port.
- Round-robin arbitrates both clients onto the single write port.
- Forwards same-cycle write data to colliding reads.
- Returns read data with a valid strobe aligned to the wrapper's read latency.

## Interface
Parameters:
- `LATCHRD`, 1: must equal the wrapper's `LATCHRD`. Read latency is 1+`LATCHRD` cycles.
- `INIT_VAL`, 32'h0: value written to every entry during init.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  pulse in RUN restarts initialisation.
- `init_done`  out  1  high in RUN only.
- `a_rd_req`, `b_rd_req`  in  1  read request, one per client.
- `a_rd_adr`, `b_rd_adr`  in  [0:4]  read address.
- `a_rd_vld`, `b_rd_vld`  out  1  read data valid.
- `a_rd_dat`, `b_rd_dat`  out  [0:31]  read data.
- `a_wr_req`, `b_wr_req`  in  1  write request; held until granted.
- `a_wr_adr`, `b_wr_adr`  in  [0:4]  write address.
- `a_wr_dat`, `b_wr_dat`  in  [0:31]  write data.
- `a_wr_gnt`, `b_wr_gnt`  out  1  combinational grant; the write is accepted in that cycle.
- `arr_rd_enb_0`, `arr_rd_adr_0[0:4]`, `arr_rd_enb_1`, `arr_rd_adr_1[0:4]`  out  array read controls (port 0 = A, port 1 = B).
- `arr_wr_enb_0`, `arr_wr_adr_0[0:4]`, `arr_wr_dat_0[0:31]`  out  array write controls.
- `arr_rd_dat_0`, `arr_rd_dat_1`  in  [0:31]  wrapper read data.

## Operation
FSM states: IDLE, INIT, RUN. Reset state is IDLE.
- IDLE: all `arr_*` enables low, all grants low, `init_done`=0. Next state is INIT unconditionally.
- INIT: 5-bit counter `icnt` runs 0..31.
  - Array write controls: `arr_wr_enb_0`=1, `arr_wr_adr_0`=`icnt`, `arr_wr_dat_0`=`INIT_VAL`.
  - Client grants and read enables are forced 0.
  - When `icnt`==31, next state is RUN and `icnt` returns to 0.
  - `clear` is ignored in INIT.
- RUN: `init_done`=1.
  - Reads: `arr_rd_enb_0`=`a_rd_req`, `arr_rd_adr_0`=`a_rd_adr`; same for B on port 1. Reads are never refused.
  - Write arbitration:
    - If only one client requests, that client is granted.
    - If both request, grant goes to the client named by priority pointer `rr` (reset value A); `rr` then flips to the other client.
    - A single requester does not change `rr`.
  - The granted client's address and data drive `arr_wr_*`, with `arr_wr_enb_0`=1.
  - `clear`=1 sends the next state to INIT. Grants and read enables are still honoured in the `clear` cycle.
- Collision bypass (write-first): if a read enable and the write enable are both asserted in the same cycle to the same address, the read returns the write data, not the array output.
  - Applies in RUN to either read port, or to both.
  - The flag and data are captured into a pipeline per port.
- Read return pipeline: one valid shift register per port, depth 1+`LATCHRD`, plus bypass flag and bypass data stages.
  - `x_rd_dat` = bypass flag ? piped write data : `arr_rd_dat_x`.
  - When `x_rd_vld`=0, `x_rd_dat` is don't-care.
- Reads issued before a `clear` still return valid data during INIT.

## Timing
- Cycle N: request, grant and `arr_*` driven (combinational).
- The wrapper registers the controls at the edge ending cycle N. The array access occurs in cycle N+1.
- `x_rd_vld` is high in cycle N+1+`LATCHRD` (N+2 by default) for exactly one cycle per request. Back-to-back reads give back-to-back valids.
- Write in cycle N, read of the same address in cycle N+1 or later: the array supplies the new data (no bypass needed).
- Reset values:
  - `init_done`=0, all grants=0, all `arr_*` enables=0, both `rd_vld`=0.
  - `rr`=A, `icnt`=0, all pipelines cleared.
- Reset asserted mid-INIT or mid-RUN returns the block to IDLE immediately. In-flight reads are dropped.
- Initialisation takes 33 cycles from reset deassertion: IDLE 1 cycle, INIT 32 cycles.

## Structure
- Shared package `ra_ctl_pkg`:
  - FSM state encoding (IDLE/INIT/RUN).
  - Constants `RA_DEPTH`=32, `RA_AW`=5, `RA_DW`=32.
- One sub-module, `ra_rd_return_pipe`, instantiated per read port. It holds the valid, bypass flag, bypass data and output mux for one read port.
- The write arbiter and FSM live in the top module.

## Test plan
- Init: release `reset_n`, check the following.
  - `arr_wr_enb_0` is high for 32 cycles with addresses 0..31 and data `INIT_VAL`.
  - `init_done` rises in cycle 33.
  - Read of address 7 returns 0 with `a_rd_vld` two cycles after the request.
- Arbitration: both clients request continuously for 4 writes each. Grants must alternate A,B,A,B… (A first after reset). A lone B request must not change `rr`.
- Bypass: in one cycle, A writes 0xDEADBEEF to address 5 while A reads 5 and B reads 5. Both ports must return 0xDEADBEEF two cycles later.
- Non-collision: write 0x12345678 to address 9 in cycle N, read 9 in cycle N+1. 0x12345678 must come from the array path with the bypass flag clear.
- Clear: issue a read, pulse `clear` in the same cycle, and check:
  - read data is still returned;
  - `init_done` drops;
  - grants stay 0 for 32 cycles;
  - afterwards, all entries read `INIT_VAL`.
- Reset mid-operation: assert `reset_n` low during INIT (`icnt`=12) and during a pending read. All outputs must go to reset values immediately, no stale `rd_vld` may appear, and a full 32-entry init must restart.

Source files
------------

// File: rtl/ra_ctl_pkg.sv
// Shared constants and state encodings for the 2R1W 32x32 register-array controller.
package ra_ctl_pkg;

    localparam int RA_DEPTH = 32;
    localparam int RA_AW    = 5;
    localparam int RA_DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } ctl_state_e;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_e;

endpackage

// File: rtl/ra_rd_return_pipe.sv
// Per-port read return path: valid, write-first bypass flag and bypass data
// delayed to match the array read latency, then muxed onto the client data.
module ra_rd_return_pipe
    import ra_ctl_pkg::*;
#(
    parameter int LATCHRD = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_enb,
    input  logic             byp,
    input  logic [0:RA_DW-1] byp_dat,
    input  logic [0:RA_DW-1] arr_rd_dat,
    output logic             rd_vld,
    output logic [0:RA_DW-1] rd_dat
);

    localparam int DEPTH = 1 + LATCHRD;

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] byp_q;
    logic [0:RA_DW-1] dat_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            byp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_enb;
            byp_q[0] <= byp;
            dat_q[0] <= byp_dat;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                byp_q[i] <= byp_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rd_vld = vld_q[DEPTH-1];
    assign rd_dat = byp_q[DEPTH-1] ? dat_q[DEPTH-1] : arr_rd_dat;

endmodule

// File: rtl/ra_2r1w_32x32_ctl.sv
// Init sequencer, round-robin write arbiter and read return logic in front of
// the 2R1W 32x32 register-array wrapper.
module ra_2r1w_32x32_ctl
    import ra_ctl_pkg::*;
#(
    parameter int               LATCHRD  = 1,
    parameter logic [0:RA_DW-1] INIT_VAL = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    output logic             init_done,
    input  logic             a_rd_req,
    input  logic [0:RA_AW-1] a_rd_adr,
    output logic             a_rd_vld,
    output logic [0:RA_DW-1] a_rd_dat,
    input  logic             b_rd_req,
    input  logic [0:RA_AW-1] b_rd_adr,
    output logic             b_rd_vld,
    output logic [0:RA_DW-1] b_rd_dat,
    input  logic             a_wr_req,
    input  logic [0:RA_AW-1] a_wr_adr,
    input  logic [0:RA_DW-1] a_wr_dat,
    output logic             a_wr_gnt,
    input  logic             b_wr_req,
    input  logic [0:RA_AW-1] b_wr_adr,
    input  logic [0:RA_DW-1] b_wr_dat,
    output logic             b_wr_gnt,
    output logic             arr_rd_enb_0,
    output logic [0:RA_AW-1] arr_rd_adr_0,
    output logic             arr_rd_enb_1,
    output logic [0:RA_AW-1] arr_rd_adr_1,
    output logic             arr_wr_enb_0,
    output logic [0:RA_AW-1] arr_wr_adr_0,
    output logic [0:RA_DW-1] arr_wr_dat_0,
    input  logic [0:RA_DW-1] arr_rd_dat_0,
    input  logic [0:RA_DW-1] arr_rd_dat_1
);

    localparam logic [0:RA_AW-1] ICNT_LAST = RA_AW'(RA_DEPTH - 1);

    ctl_state_e       state_q, state_d;
    logic [0:RA_AW-1] icnt_q, icnt_d;
    rr_e              rr_q, rr_d;
    logic             byp_a, byp_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            icnt_q  <= '0;
            rr_q    <= RR_A;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        icnt_d       = icnt_q;
        rr_d         = rr_q;
        init_done    = 1'b0;
        a_wr_gnt     = 1'b0;
        b_wr_gnt     = 1'b0;
        arr_rd_enb_0 = 1'b0;
        arr_rd_enb_1 = 1'b0;
        arr_wr_enb_0 = 1'b0;
        arr_wr_adr_0 = '0;
        arr_wr_dat_0 = '0;
        case (state_q)
            ST_IDLE: state_d = ST_INIT;
            ST_INIT: begin
                arr_wr_enb_0 = 1'b1;
                arr_wr_adr_0 = icnt_q;
                arr_wr_dat_0 = INIT_VAL;
                icnt_d       = icnt_q + 5'd1;
                if (icnt_q == ICNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done    = 1'b1;
                arr_rd_enb_0 = a_rd_req;
                arr_rd_enb_1 = b_rd_req;
                // Pointer only moves on a real conflict, so a lone requester keeps its turn order.
                a_wr_gnt = a_wr_req && (!b_wr_req || (rr_q == RR_A));
                b_wr_gnt = b_wr_req && (!a_wr_req || (rr_q == RR_B));
                if (a_wr_req && b_wr_req) begin
                    rr_d = (rr_q == RR_A) ? RR_B : RR_A;
                end
                if (a_wr_gnt) begin
                    arr_wr_enb_0 = 1'b1;
                    arr_wr_adr_0 = a_wr_adr;
                    arr_wr_dat_0 = a_wr_dat;
                end else if (b_wr_gnt) begin
                    arr_wr_enb_0 = 1'b1;
                    arr_wr_adr_0 = b_wr_adr;
                    arr_wr_dat_0 = b_wr_dat;
                end
                if (clear) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arr_rd_adr_0 = a_rd_adr;
    assign arr_rd_adr_1 = b_rd_adr;

    // The array returns old data on a same-cycle collision; the pipe substitutes the write data.
    assign byp_a = arr_rd_enb_0 && arr_wr_enb_0 && (a_rd_adr == arr_wr_adr_0);
    assign byp_b = arr_rd_enb_1 && arr_wr_enb_0 && (b_rd_adr == arr_wr_adr_0);

    ra_rd_return_pipe #(.LATCHRD(LATCHRD)) u_pipe_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_enb     (arr_rd_enb_0),
        .byp        (byp_a),
        .byp_dat    (arr_wr_dat_0),
        .arr_rd_dat (arr_rd_dat_0),
        .rd_vld     (a_rd_vld),
        .rd_dat     (a_rd_dat)
    );

    ra_rd_return_pipe #(.LATCHRD(LATCHRD)) u_pipe_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_enb     (arr_rd_enb_1),
        .byp        (byp_b),
        .byp_dat    (arr_wr_dat_0),
        .arr_rd_dat (arr_rd_dat_1),
        .rd_vld     (b_rd_vld),
        .rd_dat     (b_rd_dat)
    );

endmodule

// File: tb/tb_ra_2r1w_32x32_ctl.sv
// Directed bench for ra_2r1w_32x32_ctl with a behavioural model of the
// 2R1W wrapper (controls registered, array access next cycle, data latched).
module tb_ra_2r1w_32x32_ctl;

    localparam logic [31:0] IV = 32'h0;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        init_done;
    logic        a_rd_req, b_rd_req;
    logic [0:4]  a_rd_adr, b_rd_adr;
    logic        a_rd_vld, b_rd_vld;
    logic [0:31] a_rd_dat, b_rd_dat;
    logic        a_wr_req, b_wr_req;
    logic [0:4]  a_wr_adr, b_wr_adr;
    logic [0:31] a_wr_dat, b_wr_dat;
    logic        a_wr_gnt, b_wr_gnt;
    logic        arr_rd_enb_0, arr_rd_enb_1, arr_wr_enb_0;
    logic [0:4]  arr_rd_adr_0, arr_rd_adr_1, arr_wr_adr_0;
    logic [0:31] arr_wr_dat_0;
    logic [0:31] arr_rd_dat_0, arr_rd_dat_1;

    int total = 0;
    int bad   = 0;

    ra_2r1w_32x32_ctl #(.LATCHRD(1), .INIT_VAL(IV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .init_done    (init_done),
        .a_rd_req     (a_rd_req),
        .a_rd_adr     (a_rd_adr),
        .a_rd_vld     (a_rd_vld),
        .a_rd_dat     (a_rd_dat),
        .b_rd_req     (b_rd_req),
        .b_rd_adr     (b_rd_adr),
        .b_rd_vld     (b_rd_vld),
        .b_rd_dat     (b_rd_dat),
        .a_wr_req     (a_wr_req),
        .a_wr_adr     (a_wr_adr),
        .a_wr_dat     (a_wr_dat),
        .a_wr_gnt     (a_wr_gnt),
        .b_wr_req     (b_wr_req),
        .b_wr_adr     (b_wr_adr),
        .b_wr_dat     (b_wr_dat),
        .b_wr_gnt     (b_wr_gnt),
        .arr_rd_enb_0 (arr_rd_enb_0),
        .arr_rd_adr_0 (arr_rd_adr_0),
        .arr_rd_enb_1 (arr_rd_enb_1),
        .arr_rd_adr_1 (arr_rd_adr_1),
        .arr_wr_enb_0 (arr_wr_enb_0),
        .arr_wr_adr_0 (arr_wr_adr_0),
        .arr_wr_dat_0 (arr_wr_dat_0),
        .arr_rd_dat_0 (arr_rd_dat_0),
        .arr_rd_dat_1 (arr_rd_dat_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapper model: read-first inside the array, so collisions need the controller bypass.
    logic [0:31] mem [32];
    logic        s_we;
    logic [0:4]  s_ra0, s_ra1, s_wa;
    logic [0:31] s_wd;
    always @(posedge clk) begin
        arr_rd_dat_0 <= mem[s_ra0];
        arr_rd_dat_1 <= mem[s_ra1];
        if (s_we) mem[s_wa] <= s_wd;
        s_ra0 <= arr_rd_adr_0;
        s_ra1 <= arr_rd_adr_1;
        s_we  <= arr_wr_enb_0;
        s_wa  <= arr_wr_adr_0;
        s_wd  <= arr_wr_dat_0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic        ar;  logic [0:4] aa;
        logic        br;  logic [0:4] ba;
        logic        aw;  logic [0:4] awa; logic [0:31] awd;
        logic        bw;  logic [0:4] bwa; logic [0:31] bwd;
        logic        eag; logic        ebg;
        logic        ewen; logic [0:4] ewa; logic [0:31] ewd;
        logic        eav; logic [0:31] ead;
        logic        ebv; logic [0:31] ebd;
    } vec_t;

    function automatic vec_t mk(input int ar, aa, br, ba, aw, awa, awd, bw, bwa, bwd,
                                input int eag, ebg, eav, ead, ebv, ebd);
        vec_t v;
        v.ar  = (ar != 0);  v.aa  = 5'(aa);
        v.br  = (br != 0);  v.ba  = 5'(ba);
        v.aw  = (aw != 0);  v.awa = 5'(awa); v.awd = 32'(awd);
        v.bw  = (bw != 0);  v.bwa = 5'(bwa); v.bwd = 32'(bwd);
        v.eag = (eag != 0); v.ebg = (ebg != 0);
        v.ewen = v.eag | v.ebg;
        v.ewa  = v.eag ? v.awa : v.bwa;
        v.ewd  = v.eag ? v.awd : v.bwd;
        v.eav = (eav != 0); v.ead = 32'(ead);
        v.ebv = (ebv != 0); v.ebd = 32'(ebd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear    = 1'b0;
        a_rd_req = 1'b0; a_rd_adr = '0;
        b_rd_req = 1'b0; b_rd_adr = '0;
        a_wr_req = 1'b0; a_wr_adr = '0; a_wr_dat = '0;
        b_wr_req = 1'b0; b_wr_adr = '0; b_wr_dat = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_a_gnt"}, 32'(a_wr_gnt), 32'd0);
        chk({tag, "_b_gnt"}, 32'(b_wr_gnt), 32'd0);
        chk({tag, "_rd_enb_0"}, 32'(arr_rd_enb_0), 32'd0);
        chk({tag, "_rd_enb_1"}, 32'(arr_rd_enb_1), 32'd0);
        chk({tag, "_wr_enb"}, 32'(arr_wr_enb_0), 32'd0);
        chk({tag, "_a_vld"}, 32'(a_rd_vld), 32'd0);
        chk({tag, "_b_vld"}, 32'(b_rd_vld), 32'd0);
    endtask

    // Entered at +1 of the cycle in which reset_n was released (IDLE cycle).
    task automatic chk_init(input string tag);
        #3;
        chk({tag, "_idle_wen"}, 32'(arr_wr_enb_0), 32'd0);
        chk({tag, "_idle_done"}, 32'(init_done), 32'd0);
        for (int i = 0; i < 32; i++) begin
            step(); #3;
            chk({tag, "_wen"}, 32'(arr_wr_enb_0), 32'd1);
            chk({tag, "_wadr"}, 32'(arr_wr_adr_0), 32'(i));
            chk({tag, "_wdat"}, 32'(arr_wr_dat_0), IV);
            chk({tag, "_done_lo"}, 32'(init_done), 32'd0);
            chk({tag, "_vld"}, 32'({a_rd_vld, b_rd_vld}), 32'd0);
        end
        step(); #3;
        chk({tag, "_done_hi"}, 32'(init_done), 32'd1);
        chk({tag, "_run_wen"}, 32'(arr_wr_enb_0), 32'd0);
    endtask

    vec_t vt [23];

    initial begin
        // ar aa br ba | aw awa awd | bw bwa bwd | eag ebg | eav ead | ebv ebd
        vt[0]  = mk(1, 7, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0,            0, 0);
        vt[1]  = mk(0, 0, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0,            0, 0);
        vt[2]  = mk(0, 0, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 1, 0,            0, 0);
        vt[3]  = mk(0, 0, 0, 0,   1, 1, 32'hA0000001, 1, 11, 32'hB0000011, 1, 0, 0, 0,           0, 0);
        vt[4]  = mk(0, 0, 0, 0,   1, 2, 32'hA0000002, 1, 11, 32'hB0000011, 0, 1, 0, 0,           0, 0);
        vt[5]  = mk(0, 0, 0, 0,   1, 2, 32'hA0000002, 1, 12, 32'hB0000012, 1, 0, 0, 0,           0, 0);
        vt[6]  = mk(0, 0, 0, 0,   1, 3, 32'hA0000003, 1, 12, 32'hB0000012, 0, 1, 0, 0,           0, 0);
        vt[7]  = mk(0, 0, 0, 0,   1, 3, 32'hA0000003, 1, 13, 32'hB0000013, 1, 0, 0, 0,           0, 0);
        vt[8]  = mk(0, 0, 0, 0,   1, 4, 32'hA0000004, 1, 13, 32'hB0000013, 0, 1, 0, 0,           0, 0);
        vt[9]  = mk(0, 0, 0, 0,   1, 4, 32'hA0000004, 1, 14, 32'hB0000014, 1, 0, 0, 0,           0, 0);
        vt[10] = mk(0, 0, 0, 0,   0, 0, 0,            1, 14, 32'hB0000014, 0, 1, 0, 0,           0, 0);
        vt[11] = mk(0, 0, 0, 0,   1, 20, 32'hC0000020, 1, 21, 32'hC0000021, 0, 1, 0, 0,          0, 0);
        vt[12] = mk(0, 0, 0, 0,   1, 20, 32'hC0000020, 0, 0, 0,           1, 0, 0, 0,            0, 0);
        vt[13] = mk(0, 0, 0, 0,   1, 22, 32'hC0000022, 1, 21, 32'hC0000021, 1, 0, 0, 0,          0, 0);
        vt[14] = mk(0, 0, 0, 0,   0, 0, 0,            1, 21, 32'hC0000021, 0, 1, 0, 0,           0, 0);
        vt[15] = mk(1, 1, 1, 11,  0, 0, 0,            0, 0, 0,            0, 0, 0, 0,            0, 0);
        vt[16] = mk(1, 14, 1, 4,  0, 0, 0,            0, 0, 0,            0, 0, 0, 0,            0, 0);
        vt[17] = mk(1, 21, 1, 22, 0, 0, 0,            0, 0, 0,            0, 0, 1, 32'hA0000001, 1, 32'hB0000011);
        vt[18] = mk(1, 5, 1, 5,   1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 1, 32'hB0000014, 1, 32'hA0000004);
        vt[19] = mk(0, 0, 0, 0,   0, 0, 0,            1, 9, 32'h12345678, 0, 1, 1, 32'hC0000021, 1, 32'hC0000022);
        vt[20] = mk(1, 9, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        vt[21] = mk(0, 0, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 0, 0,            0, 0);
        vt[22] = mk(0, 0, 0, 0,   0, 0, 0,            0, 0, 0,            0, 0, 1, 32'h12345678, 0, 0);

        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #4;
        chk_reset_outs("rst");
        step();
        reset_n = 1'b1;
        chk_init("init0");

        for (int k = 0; k < 23; k++) begin
            step();
            a_rd_req = vt[k].ar; a_rd_adr = vt[k].aa;
            b_rd_req = vt[k].br; b_rd_adr = vt[k].ba;
            a_wr_req = vt[k].aw; a_wr_adr = vt[k].awa; a_wr_dat = vt[k].awd;
            b_wr_req = vt[k].bw; b_wr_adr = vt[k].bwa; b_wr_dat = vt[k].bwd;
            #3;
            $display("vec %0d: a_gnt=%b b_gnt=%b wen=%b a_vld=%b a_dat=%h b_vld=%b b_dat=%h",
                     k, a_wr_gnt, b_wr_gnt, arr_wr_enb_0, a_rd_vld, a_rd_dat, b_rd_vld, b_rd_dat);
            chk("vec_a_gnt", 32'(a_wr_gnt), 32'(vt[k].eag));
            chk("vec_b_gnt", 32'(b_wr_gnt), 32'(vt[k].ebg));
            chk("vec_wen", 32'(arr_wr_enb_0), 32'(vt[k].ewen));
            if (vt[k].ewen) begin
                chk("vec_wadr", 32'(arr_wr_adr_0), 32'(vt[k].ewa));
                chk("vec_wdat", 32'(arr_wr_dat_0), 32'(vt[k].ewd));
            end
            chk("vec_rd_enb_0", 32'(arr_rd_enb_0), 32'(vt[k].ar));
            chk("vec_rd_enb_1", 32'(arr_rd_enb_1), 32'(vt[k].br));
            chk("vec_a_vld", 32'(a_rd_vld), 32'(vt[k].eav));
            if (vt[k].eav) chk("vec_a_dat", 32'(a_rd_dat), 32'(vt[k].ead));
            chk("vec_b_vld", 32'(b_rd_vld), 32'(vt[k].ebv));
            if (vt[k].ebv) chk("vec_b_dat", 32'(b_rd_dat), 32'(vt[k].ebd));
        end

        // Clear with a read and a write in the same cycle.
        step();
        idle_inputs();
        clear = 1'b1;
        a_rd_req = 1'b1; a_rd_adr = 5'd20;
        a_wr_req = 1'b1; a_wr_adr = 5'd30; a_wr_dat = 32'h30303030;
        #3;
        chk("clr_a_gnt", 32'(a_wr_gnt), 32'd1);
        chk("clr_done", 32'(init_done), 32'd1);
        chk("clr_rd_enb", 32'(arr_rd_enb_0), 32'd1);
        step();
        clear = 1'b0;
        b_rd_req = 1'b1; b_rd_adr = 5'd3;
        b_wr_req = 1'b1; b_wr_adr = 5'd31; b_wr_dat = 32'h31313131;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step();
            #3;
            chk("clr_init_done", 32'(init_done), 32'd0);
            chk("clr_gnt", 32'({a_wr_gnt, b_wr_gnt}), 32'd0);
            chk("clr_rd_enb", 32'({arr_rd_enb_0, arr_rd_enb_1}), 32'd0);
            chk("clr_wen", 32'(arr_wr_enb_0), 32'd1);
            chk("clr_wadr", 32'(arr_wr_adr_0), 32'(i));
            chk("clr_a_vld", 32'(a_rd_vld), 32'(i == 1));
            if (i == 1) chk("clr_a_dat", 32'(a_rd_dat), 32'hC0000020);
            chk("clr_b_vld", 32'(b_rd_vld), 32'd0);
        end
        step();
        idle_inputs();
        #3;
        chk("clr_done_hi", 32'(init_done), 32'd1);

        for (int k = 0; k < 34; k++) begin
            step();
            a_rd_req = (k < 32); a_rd_adr = 5'(k);
            b_rd_req = (k < 32); b_rd_adr = 5'(31 - k);
            #3;
            if (k >= 2) begin
                chk("rb_a_vld", 32'(a_rd_vld), 32'd1);
                chk("rb_a_dat", 32'(a_rd_dat), IV);
                chk("rb_b_vld", 32'(b_rd_vld), 32'd1);
                chk("rb_b_dat", 32'(b_rd_dat), IV);
            end else begin
                chk("rb_vld_lo", 32'({a_rd_vld, b_rd_vld}), 32'd0);
            end
        end

        // Reset while a read is in flight.
        step();
        idle_inputs();
        a_rd_req = 1'b1; a_rd_adr = 5'd3;
        step();
        idle_inputs();
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rst_rd");
        repeat (2) begin
            step(); #3;
            chk("rst_rd_stale_vld", 32'({a_rd_vld, b_rd_vld}), 32'd0);
        end

        // Release, then reset again part-way through init.
        step();
        reset_n = 1'b1;
        #3;
        chk("rst_mid_idle_wen", 32'(arr_wr_enb_0), 32'd0);
        for (int i = 0; i <= 12; i++) begin
            step(); #3;
            chk("rst_mid_wadr", 32'(arr_wr_adr_0), 32'(i));
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rst_init");
        step();
        step();
        reset_n = 1'b1;
        chk_init("init2");

        step();
        b_rd_req = 1'b1; b_rd_adr = 5'd7;
        step();
        idle_inputs();
        #3;
        chk("final_b_vld_lo", 32'(b_rd_vld), 32'd0);
        step(); #3;
        chk("final_b_vld", 32'(b_rd_vld), 32'd1);
        chk("final_b_dat", 32'(b_rd_dat), IV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
